mul8s_rr_arbiter: RTL and testbench
===================================

MUL8S_RR_ARBITER -- requirements
Module: mul8s_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port req_valid, input, NREQ: requester i has an operand pair pending.
REQ-005 SHALL have port req_ready, output, NREQ: one-hot or zero; requester i accepted this cycle.
REQ-006 SHALL have port req_a, input, 8*NREQ: packed signed multiplicands; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_b, input, 8*NREQ: packed signed multipliers; same packing as req_a.
REQ-008 SHALL have port rsp_valid, output, 1: result register holds a valid product.
REQ-009 SHALL have port rsp_ready, input, 1: consumer accepts the result this cycle.
REQ-010 SHALL have port rsp_y, output, 16: signed product a*b.
REQ-011 SHALL have port rsp_id, output, 3: index of the requester that owns rsp_y.

Function
REQ-012 SHALL share one combinational signed 8x8 multiplier among all requesters.
REQ-013 SHALL treat a handshake as complete when req_valid[i] and req_ready[i] are both 1 on the same posedge.
REQ-014 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid=1.
REQ-015 SHALL accept a request only when (rsp_valid=0) or (rsp_valid=1 and rsp_ready=1), so one accept per cycle and full throughput under no backpressure.
REQ-016 SHALL select the winner by round-robin: search starts at ptr and proceeds through ptr+1, ..., wrapping at NREQ-1 to 0.
REQ-017 SHALL update ptr to (winner+1) mod NREQ on each accept, and leave it unchanged otherwise.
REQ-018 SHALL load rsp_y = signed(a)*signed(b) (16-bit, two's complement, no saturation) and rsp_id = winner on accept; rsp_valid=1 on the next cycle (latency 1).
REQ-019 SHALL drop rsp_valid to 0 when rsp_valid=1, rsp_ready=1, and no new accept occurs.
REQ-020 SHALL hold rsp_y, rsp_id, and rsp_valid stable while rsp_valid=1 and rsp_ready=0, with req_ready all 0.
REQ-021 SHALL implement an explicit FSM with two states:
  - EMPTY: rsp_valid=0; goes to FULL on accept.
  - FULL: goes to EMPTY on drain without accept; stays FULL on drain with accept or on stall.
REQ-022 SHALL drive req_ready combinationally from req_valid, ptr, state, and rsp_ready, with no combinational path from req_a or req_b.
REQ-023 SHALL ignore operand changes on requesters not granted; a pending requester may drop req_valid without a handshake.
REQ-024 SHALL produce exact results at the corners: -128*-128=16384, -128*127=-16256, -128*-1=128, 127*127=16129.

Reset
REQ-025 SHALL, when rst_n=0 at posedge, set state=EMPTY, rsp_valid=0, rsp_y=0, rsp_id=0, ptr=0.
REQ-026 SHALL force req_ready=0 while rst_n=0.
REQ-027 SHALL discard any in-flight or stalled result on reset mid-operation; the first accept after reset follows ptr=0.

Structure
REQ-028 SHALL take NREQ default, state encodings (EMPTY=0, FULL=1), and ID width (3) from shared package mul8s_pkg.
REQ-029 SHALL instantiate the existing mul8s_fast as its only sub-module, fed by the winner-selected operand mux.
REQ-030 SHALL keep round-robin search, FSM, and output register in this module (target 150-250 lines).

Verification
REQ-031 SHALL cover single request: req_valid=0001, a=-128, b=-1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_y=128, rsp_id=0.
REQ-032 SHALL cover all four valid from reset with rsp_ready=1 held -> accepts in order 0,1,2,3 on consecutive cycles; products match a*b.
REQ-033 SHALL cover persistent contenders: req1 and req2 continuously valid -> grants alternate 1,2,1,2; no starvation.
REQ-034 SHALL cover backpressure: rsp_ready=0 for 3 cycles with rsp_valid=1, rsp_y=16129 -> outputs stable, req_ready=0000; rsp_ready=1 -> drain and new accept in same cycle.
REQ-035 SHALL cover reset mid-stall: rst_n=0 for one cycle during FULL -> rsp_valid=0, ptr=0; next accept is the lowest valid index.
REQ-036 SHALL cover self-check: 200 random operand/valid/rsp_ready cycles -> every rsp_y equals a*b of the recorded request for rsp_id, and each request is answered exactly once.

Source files
------------

// File: rtl/mul8s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul8s_pkg
// Description : Shared constants for the mul8s family: default requester
//               count, result-owner ID width and the two-state encoding of
//               the arbiter's result register.
// Revision    : 1.0 - initial release
// ============================================================================
package mul8s_pkg;

    // Default number of requesters sharing one multiplier (legal 2..8)
    localparam int c_nreq_default = 4;

    // Width of the requester index carried with each result
    localparam int c_id_w = 3;

    // Result-register state encoding
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

endpackage : mul8s_pkg
`default_nettype wire

// File: rtl/mul8s_fast.sv
`default_nettype none
// ============================================================================
// Module      : mul8s_fast
// Description : Purely combinational signed 8x8 -> 16 multiplier.
//               Two's complement, full-precision result, no saturation.
// Ports       : i_a  - signed multiplicand
//               i_b  - signed multiplier
//               o_y  - signed product i_a * i_b
// Revision    : 1.0 - initial release
// ============================================================================
module mul8s_fast (
    input  logic signed [7:0]  i_a,
    input  logic signed [7:0]  i_b,
    output logic signed [15:0] o_y
);

    // Both operands are signed, so the 16-bit context sign-extends them
    // before multiplying; -128*-128 = 16384 still fits.
    assign o_y = i_a * i_b;

endmodule : mul8s_fast
`default_nettype wire

// File: rtl/mul8s_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul8s_rr_arbiter
// Description : Round-robin arbiter in front of a single shared signed 8x8
//               multiplier. One request is accepted per cycle into a
//               one-entry result register (latency 1). Backpressure on the
//               result side blocks all acceptances until it drains.
// Ports       : clk        - clock, all state on rising edge
//               rst_n      - synchronous active-low reset
//               req_valid  - per-requester operand pair pending
//               req_ready  - one-hot (or zero) accept strobe
//               req_a      - packed signed multiplicands, 8 bits each
//               req_b      - packed signed multipliers, 8 bits each
//               rsp_valid  - result register holds a product
//               rsp_ready  - consumer takes the result this cycle
//               rsp_y      - signed product
//               rsp_id     - index of the requester owning rsp_y
// Revision    : 1.0 - initial release
// ============================================================================
module mul8s_rr_arbiter
    import mul8s_pkg::*;
#(
    parameter int NREQ = c_nreq_default
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [8*NREQ-1:0]     req_a,
    input  logic [8*NREQ-1:0]     req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_y,
    output logic [c_id_w-1:0]     rsp_id
);

    // Requester count and last index in pointer arithmetic width
    localparam logic [c_id_w:0]   c_nreq = (c_id_w + 1)'(NREQ);
    localparam logic [c_id_w-1:0] c_last = c_id_w'(NREQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [c_id_w-1:0]       r_ptr;
    logic [15:0]             r_y;
    logic [c_id_w-1:0]       r_id;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    logic [2*NREQ-1:0]       w_dbl;
    logic [NREQ-1:0]         w_rot;
    logic                    w_found;
    logic [c_id_w-1:0]       w_off;
    logic [c_id_w:0]         w_sum;
    logic [c_id_w-1:0]       w_win;
    logic                    w_accept;

    // Rotating a doubled copy right by ptr puts requester (ptr+k) mod NREQ
    // at bit k, so a fixed-priority scan from bit 0 is the round-robin scan.
    assign w_dbl = {req_valid, req_valid} >> r_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_id_w'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute requester index
    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_nreq) begin
            w_sum = w_sum - c_nreq;
        end
        w_win = w_sum[c_id_w-1:0];
    end

    // A slot is free when empty or when the held result drains this cycle.
    // Operands never reach this path, only valid/ptr/state/rsp_ready.
    assign w_accept = rst_n && w_found &&
                      ((r_state == c_st_empty) || rsp_ready);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept && (w_win == c_id_w'(i));
        end
    end

    // ------------------------------------------------------------------
    // Operand mux and shared multiplier
    // ------------------------------------------------------------------
    logic signed [7:0]       w_a;
    logic signed [7:0]       w_b;
    logic signed [15:0]      w_prod;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_id_w'(i)) begin
                w_a = req_a[8*i +: 8];
                w_b = req_b[8*i +: 8];
            end
        end
    end

    mul8s_fast u_mul (
        .i_a (w_a),
        .i_b (w_b),
        .o_y (w_prod)
    );

    // ------------------------------------------------------------------
    // Result-register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_accept) begin
                    w_state_nxt = c_st_full;
                end
            end
            c_st_full: begin
                // Drain with a simultaneous accept keeps the register full
                if (rsp_ready && !w_accept) begin
                    w_state_nxt = c_st_empty;
                end
            end
            default: begin
                w_state_nxt = c_st_empty;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result payload and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_accept) begin
            r_y   <= w_prod;
            r_id  <= w_win;
            r_ptr <= (w_win == c_last) ? '0 : w_win + 1'b1;
        end
    end

    assign rsp_valid = (r_state == c_st_full);
    assign rsp_y     = r_y;
    assign rsp_id    = r_id;

endmodule : mul8s_rr_arbiter
`default_nettype wire

// File: tb/tb_mul8s_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul8s_rr_arbiter
// Description : Self-checking bench for mul8s_rr_arbiter. A behavioural
//               model (modular round-robin search, integer products) is
//               compared with the DUT every cycle; a scoreboard pairs each
//               handshake with its response; directed sequences pin literal
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul8s_rr_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [8*N-1:0]   req_a;
    logic [8*N-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_y;
    logic [2:0]       rsp_id;

    always #5 clk = ~clk;

    mul8s_rr_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model of the result register and pointer
    int m_full = 0;
    int m_y    = 0;
    int m_id   = 0;
    int m_ptr  = 0;

    // Scoreboard of accepted, not yet answered requests
    int sb_id[$];
    int sb_y[$];

    // req_ready as sampled mid-cycle by the most recent step
    int last_rr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int opa(input int i);
        logic signed [7:0] v;
        v = req_a[8*i +: 8];
        return int'(v);
    endfunction

    function automatic int opb(input int i);
        logic signed [7:0] v;
        v = req_b[8*i +: 8];
        return int'(v);
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
    endtask

    // Winner the model expects this cycle, or -1 for no accept
    function automatic int exp_grant();
        int idx;
        if (rst_n !== 1'b1) return -1;
        if (m_full != 0 && rsp_ready !== 1'b1) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: entered at posedge+1 with inputs already driven,
    // compares at the falling edge, then advances the model at the edge.
    task automatic step();
        int g;
        int sy;
        int sid;
        #4;
        g = exp_grant();
        last_rr = int'(req_ready);
        chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        chk("rsp_valid", int'(rsp_valid), m_full);
        chk("rsp_y", int'($signed(rsp_y)), m_y);
        chk("rsp_id", int'(rsp_id), m_id);

        if (rst_n !== 1'b1) begin
            sb_id.delete();
            sb_y.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_y.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: response id %0d with no pending request", rsp_id);
                end else begin
                    sy  = sb_y.pop_front();
                    sid = sb_id.pop_front();
                    chk("sb_y", int'($signed(rsp_y)), sy);
                    chk("sb_id", int'(rsp_id), sid);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_id.push_back(i);
                    sb_y.push_back(opa(i) * opb(i));
                end
            end
        end

        if (rst_n !== 1'b1) begin
            m_full = 0; m_y = 0; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_full = 1;
            m_y    = opa(g) * opb(g);
            m_id   = g;
            m_ptr  = (g + 1) % N;
        end else if (m_full != 0 && rsp_ready) begin
            m_full = 0;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int ids2[4];
        int ys2[4];
        ids2 = '{0, 1, 2, 3};
        ys2  = '{16384, -16256, 128, 16129};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_y", int'($signed(rsp_y)), 0);
        chk("rst_id", int'(rsp_id), 0);

        // Single request: -128 * -1
        set_op(0, -128, -1);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        chk("single_valid", int'(rsp_valid), 1);
        chk("single_y", int'($signed(rsp_y)), 128);
        chk("single_id", int'(rsp_id), 0);
        step();
        chk("single_drain", int'(rsp_valid), 0);

        // All four valid from reset, corner operands
        do_reset();
        set_op(0, -128, -128);
        set_op(1, -128, 127);
        set_op(2, -128, -1);
        set_op(3, 127, 127);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("all4_id", int'(rsp_id), ids2[k]);
            chk("all4_y", int'($signed(rsp_y)), ys2[k]);
        end

        // Persistent contenders 1 and 2 alternate
        req_valid = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_id", int'(rsp_id), (k % 2 == 0) ? 1 : 2);
        end

        // Backpressure with 127*127 held
        req_valid = 4'b0001;
        set_op(0, 127, 127);
        step();
        req_valid = 4'b0011;
        set_op(1, 5, -7);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_rr", last_rr, 0);
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_y", int'($signed(rsp_y)), 16129);
            chk("bp_id", int'(rsp_id), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_rr", last_rr, 2);
        chk("bp_release_y", int'($signed(rsp_y)), -35);
        chk("bp_release_id", int'(rsp_id), 1);

        // Reset during a stall
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_rr", last_rr, 0);
        chk("midrst_valid", int'(rsp_valid), 0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_op(1, -3, 9);
        step();
        chk("midrst_id", int'(rsp_id), 1);
        chk("midrst_y", int'($signed(rsp_y)), -27);

        // Random traffic
        for (int c = 0; c < 200; c++) begin
            req_valid = N'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain and confirm every request was answered once
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("sb_left", sb_y.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mul8s_rr_arbiter
`default_nettype wire
